// File: rtl/cpu_reset_seq_if.sv
// Reset-vector read port between the reset sequencer and program memory.
interface cpu_reset_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_reset_seq.sv
// Reset stretcher and boot sequencer for the MSP430 core: merges reset requests,
// fetches the reset vector and hands PC/SP/SR initial values to the core.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_HOLD    | core held in reset, hold timer running (reloaded by any request)
// ST_FETCH   | reset vector read outstanding, timeout timer running
// ST_RELEASE | init values valid, core still in reset for this one cycle
// ST_RUN     | core running; stays here until a request or power-on reset
module cpu_reset_seq #(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 16,
    parameter int                NUM_SRC       = 4,
    parameter int                HOLD_CYCLES   = 4,
    parameter logic [ADDR_W-1:0] VEC_ADDR      = 16'hFFFE,
    parameter logic [DATA_W-1:0] SP_INIT       = 16'h0400,
    parameter logic [DATA_W-1:0] SR_INIT       = 16'h0000,
    parameter int                FETCH_TIMEOUT = 8,
    parameter logic [DATA_W-1:0] FALLBACK_PC   = 16'hC000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    cpu_reset_seq_if.master    mem,
    output logic               core_rst,
    output logic [DATA_W-1:0]  pc_init,
    output logic [DATA_W-1:0]  sp_init,
    output logic [DATA_W-1:0]  sr_init,
    output logic               init_valid,
    output logic               vec_fault,
    output logic               por_flag,
    output logic [NUM_SRC-1:0] rst_cause,
    input  logic               cause_clr
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_FETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int TMR_MAX = (HOLD_CYCLES > FETCH_TIMEOUT) ? HOLD_CYCLES : FETCH_TIMEOUT;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  FETCH_LOAD = TMR_W'(FETCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [DATA_W-1:0] PC_MASK    = ~DATA_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic [DATA_W-1:0] pc_nxt;
    logic              req_any;
    logic              fetch_to;

    assign req_any = |src_req;

    // One down-counter serves both the hold stretch and the fetch timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_HOLD;
            tmr   <= HOLD_LOAD;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pc_nxt    = pc_init;
        fetch_to  = 1'b0;
        if (req_any) begin
            state_nxt = ST_HOLD;
            tmr_nxt   = HOLD_LOAD;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (tmr == '0) begin
                        state_nxt = ST_FETCH;
                        tmr_nxt   = FETCH_LOAD;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
                ST_FETCH: begin
                    // A late ack in the terminal cycle still counts as a good fetch.
                    if (mem.mem_ack) begin
                        pc_nxt    = mem.mem_rdata & PC_MASK;
                        state_nxt = ST_RELEASE;
                    end else if (tmr == '0) begin
                        pc_nxt    = FALLBACK_PC;
                        fetch_to  = 1'b1;
                        state_nxt = ST_RELEASE;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
                ST_RELEASE: state_nxt = ST_RUN;
                ST_RUN:     state_nxt = ST_RUN;
                default:    state_nxt = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_init   <= FALLBACK_PC;
            sp_init   <= SP_INIT;
            sr_init   <= SR_INIT;
            vec_fault <= 1'b0;
            por_flag  <= 1'b1;
            rst_cause <= '0;
        end else begin
            pc_init   <= pc_nxt;
            sp_init   <= SP_INIT;
            sr_init   <= SR_INIT;
            // New events win over a simultaneous clear.
            vec_fault <= (vec_fault & ~cause_clr) | fetch_to;
            por_flag  <= por_flag & ~cause_clr;
            rst_cause <= (rst_cause & {NUM_SRC{~cause_clr}}) | src_req;
        end
    end

    assign mem.mem_rd   = (state == ST_FETCH);
    assign mem.mem_addr = VEC_ADDR;
    assign core_rst     = (state != ST_RUN);
    assign init_valid   = (state == ST_RELEASE) || (state == ST_RUN);

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: directed boot scenarios plus randomized request/ack
// sequences, checked against latency formulas and a sticky-flag model.
module tb_cpu_reset_seq;

    localparam int          H   = 4;
    localparam int          T   = 8;
    localparam logic [15:0] VEC = 16'hFFFE;
    localparam logic [15:0] SPI = 16'h0400;
    localparam logic [15:0] SRI = 16'h0000;
    localparam logic [15:0] FB  = 16'hC000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [3:0]  src_req   = 4'b0;
    logic        cause_clr = 1'b0;
    logic        core_rst;
    logic        init_valid;
    logic        vec_fault;
    logic        por_flag;
    logic [15:0] pc_init;
    logic [15:0] sp_init;
    logic [15:0] sr_init;
    logic [3:0]  rst_cause;

    cpu_reset_seq_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_pc;
    logic        exp_vf;
    logic        exp_por;
    logic [3:0]  exp_cause;

    always #5 clk = ~clk;

    cpu_reset_seq #(
        .DATA_W(16), .ADDR_W(16), .NUM_SRC(4), .HOLD_CYCLES(H),
        .VEC_ADDR(VEC), .SP_INIT(SPI), .SR_INIT(SRI),
        .FETCH_TIMEOUT(T), .FALLBACK_PC(FB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req    (src_req),
        .mem        (mem_bus),
        .core_rst   (core_rst),
        .pc_init    (pc_init),
        .sp_init    (sp_init),
        .sr_init    (sr_init),
        .init_valid (init_valid),
        .vec_fault  (vec_fault),
        .por_flag   (por_flag),
        .rst_cause  (rst_cause),
        .cause_clr  (cause_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_sticky(input string tag);
        chk({tag, "_pc"},    32'(pc_init),   32'(exp_pc));
        chk({tag, "_vf"},    32'(vec_fault), 32'(exp_vf));
        chk({tag, "_por"},   32'(por_flag),  32'(exp_por));
        chk({tag, "_cause"}, 32'(rst_cause), 32'(exp_cause));
    endtask

    // Called at a negedge; leaves the request low at a negedge, which is where
    // the hold stretch starts counting.
    task automatic trigger(input logic [3:0] pulse, input int hold, input logic clr);
        src_req   = pulse;
        cause_clr = clr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cause_clr = 1'b0;
        end
        src_req = 4'b0;
        if (clr) begin
            exp_cause = pulse;
            exp_por   = 1'b0;
            exp_vf    = 1'b0;
        end else begin
            exp_cause = exp_cause | pulse;
        end
        chk("trig_core_rst", 32'(core_rst), 32'd1);
        chk("trig_init_valid", 32'(init_valid), 32'd0);
        chk("trig_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        chk_sticky("trig");
    endtask

    // Runs from the start of a hold stretch until the core leaves reset.
    // d = number of FETCH cycles before the ack; d >= T means never ack.
    task automatic boot(input int d, input logic [15:0] data, input int base);
        logic to;
        int   n;
        int   rd_cnt;
        int   iv_n;
        logic done;
        logic addr_ok;
        to      = (d >= T);
        n       = base;
        rd_cnt  = 0;
        iv_n    = 0;
        done    = 1'b0;
        addr_ok = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 16'($urandom);
            if (mem_bus.mem_rd) begin
                rd_cnt++;
                if (mem_bus.mem_addr !== VEC) addr_ok = 1'b0;
                if (!to && rd_cnt == d + 1) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = data;
                end
            end else begin
                // Stray acks outside the fetch window must be ignored.
                mem_bus.mem_ack = 1'($urandom_range(0, 1));
            end
            if (init_valid && iv_n == 0) iv_n = n;
            if (!core_rst) done = 1'b1;
        end
        mem_bus.mem_ack = 1'b0;
        exp_pc = to ? FB : (data & 16'hFFFE);
        if (to) exp_vf = 1'b1;
        chk("boot_done", 32'(done), 32'd1);
        chk("boot_latency", 32'(n), 32'(H + (to ? T + 1 : d + 2)));
        chk("boot_rd_cycles", 32'(rd_cnt), 32'(to ? T : d + 1));
        chk("boot_release_cycle", 32'(iv_n), 32'(n - 1));
        chk("boot_addr", 32'(addr_ok), 32'd1);
        chk("boot_init_valid", 32'(init_valid), 32'd1);
        chk("boot_sp", 32'(sp_init), 32'(SPI));
        chk("boot_sr", 32'(sr_init), 32'(SRI));
        chk_sticky("boot");
    endtask

    initial begin
        logic        found;
        logic [15:0] junk;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0;
        exp_pc    = FB;
        exp_vf    = 1'b0;
        exp_por   = 1'b1;
        exp_cause = 4'b0;

        repeat (3) @(negedge clk);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'(VEC));
        chk("rst_init_valid", 32'(init_valid), 32'd0);
        chk("rst_sp", 32'(sp_init), 32'(SPI));
        chk("rst_sr", 32'(sr_init), 32'(SRI));
        chk_sticky("rst");

        rst = 1'b1;
        boot(0, 16'hC000, 0);

        trigger(4'b0100, 1, 1'b0);
        boot(1, 16'h8001, 0);

        cause_clr = 1'b1;
        @(negedge clk);
        cause_clr = 1'b0;
        exp_cause = 4'b0;
        exp_por   = 1'b0;
        exp_vf    = 1'b0;
        chk_sticky("clr");
        chk("clr_core_rst", 32'(core_rst), 32'd0);

        trigger(4'b0001, 1, 1'b0);
        boot(T, 16'h1234, 0);

        for (int it = 0; it < 10; it++) begin
            trigger(4'($urandom_range(1, 15)), $urandom_range(1, 3), 1'($urandom_range(0, 3) == 0));
            boot($urandom_range(0, T + 2), 16'($urandom), 0);
        end

        // Request during FETCH aborts it; the ack one cycle later is ignored.
        trigger(4'b0001, 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_bus.mem_rd) found = 1'b1;
        end
        chk("abort_reach_fetch", 32'(found), 32'd1);
        src_req = 4'b0010;
        @(negedge clk);
        src_req   = 4'b0;
        exp_cause = exp_cause | 4'b0010;
        chk("abort_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        chk("abort_core_rst", 32'(core_rst), 32'd1);
        chk("abort_init_valid", 32'(init_valid), 32'd0);
        junk = exp_pc ^ 16'h1230;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = junk;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("abort_mem_rd_late", 32'(mem_bus.mem_rd), 32'd0);
        chk_sticky("abort");
        boot(0, 16'hA5A5, 1);

        trigger(4'b1000, 1, 1'b1);
        boot(2, 16'h4443, 0);

        // Async reset in the middle of a fetch.
        trigger(4'b0100, 1, 1'b0);
        boot(T, 16'h0, 0);
        trigger(4'b0100, 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_bus.mem_rd) found = 1'b1;
        end
        chk("arst_reach_fetch", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_pc    = FB;
        exp_vf    = 1'b0;
        exp_por   = 1'b1;
        exp_cause = 4'b0;
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        chk("arst_init_valid", 32'(init_valid), 32'd0);
        chk("arst_sp", 32'(sp_init), 32'(SPI));
        chk_sticky("arst");
        @(negedge clk);
        rst = 1'b1;
        boot(0, 16'h2468, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
